bp_fe_cmd_queue: RTL
====================

// Module: bp_fe_cmd_queue
// PURPOSE
//  Elastic buffer between the BE command producer and the FE controller. Accepts
//  bp_fe_cmd_s packets on a ready&valid port and presents them in order on a
//  valid/yumi port to the FE controller (fe_cmd_i/fe_cmd_v_i/fe_cmd_yumi_o there).
//  Attaboys are hints: when the buffer is full they are accepted and discarded.
//  Every other opcode is back-pressured, never lost.
// PARAMETERS
//  bp_params_p  e_bp_default_cfg  config; sets fe_cmd_width_lp via declare_bp_core_if_widths
//  els_p        4                 buffer depth; legal range 2..16, non-power-of-2 allowed
//  drop_cnt_width_p 8             width of saturating attaboy-drop counter
// PORTS
//  clk_i              in   1                 clock; all state on posedge
//  reset_i            in   1                 asynchronous, active-high reset
//  fe_cmd_i           in   fe_cmd_width_lp   command from BE (bp_fe_cmd_s)
//  fe_cmd_v_i         in   1                 fe_cmd_i valid
//  fe_cmd_ready_and_o out  1                 buffer can take fe_cmd_i this cycle
//  fe_cmd_o           out  fe_cmd_width_lp   oldest buffered command
//  fe_cmd_v_o         out  1                 fe_cmd_o valid (buffer non-empty)
//  fe_cmd_yumi_i      in   1                 controller consumes fe_cmd_o this cycle
//  empty_o            out  1                 count == 0
//  full_o             out  1                 count == els_p
//  count_o            out  $clog2(els_p+1)   occupancy
//  attaboy_drop_o     out  1                 registered 1-cycle pulse: an attaboy was discarded
//  drop_cnt_o         out  drop_cnt_width_p  saturating count of discarded attaboys
// BEHAVIOUR
//  - Reset (async assert, sync-released use): rptr=wptr=0, count=0, drop state=0.
//    Outputs under reset: fe_cmd_v_o=0, empty_o=1, full_o=0, count_o=0,
//    attaboy_drop_o=0, drop_cnt_o=0, fe_cmd_ready_and_o=1. Storage is not cleared.
//    fe_cmd_o is don't-care while fe_cmd_v_o=0.
//  - Reset asserted mid-operation discards all buffered commands immediately.
//  - is_attaboy = fe_cmd_i cast opcode == e_op_attaboy.
//  - fe_cmd_ready_and_o = ~full_o | is_attaboy. It depends on fe_cmd_i only,
//    never on fe_cmd_yumi_i. There is no same-cycle full pass-through.
//  - enq = fe_cmd_v_i & ~full_o. When enq fires, fe_cmd_i is written at wptr;
//    wptr advances, wrapping from els_p-1 to 0.
//  - drop = fe_cmd_v_i & full_o & is_attaboy. The handshake completes and no
//    write occurs. Next cycle attaboy_drop_o=1 and drop_cnt_o increments,
//    saturating at all-ones.
//  - deq = fe_cmd_yumi_i & fe_cmd_v_o. rptr advances with the same wrap rule.
//    yumi while empty is illegal: assert error, state unchanged.
//  - count_n = count + enq - deq. Simultaneous enq & deq keeps count and moves
//    both pointers, including at count==1 and at count==els_p-1.
//  - Latency: an enqueued entry appears on fe_cmd_o the cycle after acceptance.
//    There is no combinational input-to-output bypass, even when empty.
//  - fe_cmd_o = mem[rptr] from a registered read pointer. It is stable while
//    fe_cmd_v_o=1 and yumi is low.
//  - Ordering is strict FIFO. Dropped attaboys never reorder the remaining entries.
//  - Assertions: yumi only when valid; count <= els_p; full_o and empty_o never both 1.
// TESTING
//  1. Reset, push 4 redirects (npc 0x100,0x104,0x108,0x10c), no yumi ->
//     full_o=1 on cycle 5, count_o=4, ready_and_o=0 for a non-attaboy.
//  2. Full, push attaboy npc=0x200 -> ready_and_o=1, no write,
//     attaboy_drop_o=1 next cycle, drop_cnt_o=1; pop order 0x100..0x10c.
//  3. count=1, simultaneous push 0x300 and yumi -> count stays 1, fe_cmd_o=0x300
//     next cycle. Run 10 back-to-back push+pop cycles across the pointer wrap;
//     no loss or reorder.
//  4. Empty, push 0x400 at cycle t -> fe_cmd_v_o=0 at t, 1 at t+1 with fe_cmd_o=0x400.
//  5. 3 entries buffered, reset_i pulsed mid-cycle asynchronously ->
//     fe_cmd_v_o=0, count_o=0 before the next clock edge.
//  6. els_p=3, drop_cnt_width_p=2, 5 attaboys dropped while full ->
//     drop_cnt_o saturates at 3.

Source files
------------

// File: rtl/bp_fe_cmd_queue.sv
// FE command queue: elastic FIFO between the BE command producer and the FE
// controller. When full, attaboy hints are accepted and discarded.
`timescale 1ns/1ps

package bp_fe_cmd_pkg;

  typedef enum int {
    e_bp_default_cfg = 0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_op_state_reset          = 4'd0,
    e_op_pc_redirection       = 4'd1,
    e_op_icache_fill_response = 4'd2,
    e_op_icache_fence         = 4'd3,
    e_op_itlb_fill_response   = 4'd4,
    e_op_itlb_fence           = 4'd5,
    e_op_attaboy              = 4'd6,
    e_op_wait                 = 4'd7
  } bp_fe_command_queue_opcodes_e;

  typedef struct packed {
    logic [23:0]                  operands;
    logic [38:0]                  npc;
    bp_fe_command_queue_opcodes_e opcode;
  } bp_fe_cmd_s;

  function automatic int fe_cmd_width(input bp_params_e cfg);
    unique case (cfg)
      e_bp_default_cfg: return $bits(bp_fe_cmd_s);
      default:          return $bits(bp_fe_cmd_s);
    endcase
  endfunction

endpackage

module bp_fe_cmd_queue
  import bp_fe_cmd_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 4,
  parameter int drop_cnt_width_p = 8,
  localparam int fe_cmd_width_lp = fe_cmd_width(bp_params_p),
  localparam int cnt_w_lp = $clog2(els_p+1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [fe_cmd_width_lp-1:0]  fe_cmd_i,
  input  logic                        fe_cmd_v_i,
  output logic                        fe_cmd_ready_and_o,
  output logic [fe_cmd_width_lp-1:0]  fe_cmd_o,
  output logic                        fe_cmd_v_o,
  input  logic                        fe_cmd_yumi_i,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [cnt_w_lp-1:0]         count_o,
  output logic                        attaboy_drop_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int op_w_lp = $bits(bp_fe_command_queue_opcodes_e);

  logic [fe_cmd_width_lp-1:0] mem_q [els_p];

  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic drop_q, drop_d;
  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

  logic is_attaboy, enq, deq, drop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p-1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // opcode occupies the low bits of bp_fe_cmd_s
  assign is_attaboy =
    (fe_cmd_i[op_w_lp-1:0] == e_op_attaboy);

  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign fe_cmd_v_o = ~empty_o;
  assign fe_cmd_o   = mem_q[rptr_q];
  assign fe_cmd_ready_and_o = ~full_o | is_attaboy;

  assign enq  = fe_cmd_v_i & ~full_o;
  assign drop = fe_cmd_v_i & full_o & is_attaboy;
  assign deq  = fe_cmd_yumi_i & fe_cmd_v_o;

  assign attaboy_drop_o = drop_q;
  assign drop_cnt_o     = drop_cnt_q;

  always_comb begin
    rptr_d  = deq ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = enq ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    drop_d  = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && ~&drop_cnt_q)
      drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // storage is intentionally left out of reset
  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr_q] <= fe_cmd_i;
  end

  a_yumi_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    fe_cmd_yumi_i |-> fe_cmd_v_o);

  a_count_max: assert property (
    @(posedge clk_i) disable iff (reset_i)
    count_q <= cnt_w_lp'(els_p));

  a_full_empty: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(full_o && empty_o));

endmodule
